// File: rtl/gf_div_pkg.sv
// Shared types for the GF(p) binary extended Euclidean divider.
// FSM state encoding and mode-select constants.
package gf_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  localparam logic MODE_INV = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/gf_bee_step.sv
// One binary extended Euclidean update on (u, v, x1, x2) modulo p.
// Pure combinational; the caller decides whether the step is taken.
module gf_bee_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] u_n,
  output logic [WIDTH-1:0] v_n,
  output logic [WIDTH-1:0] x1_n,
  output logic [WIDTH-1:0] x2_n
);

  logic             u_ge_v;
  logic [WIDTH-1:0] h_x;
  logic [WIDTH:0]   h_sum;
  logic [WIDTH-1:0] h_out;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic [WIDTH-1:0] xs_a;
  logic [WIDTH-1:0] xs_b;
  logic [WIDTH:0]   x_dif;
  logic [WIDTH-1:0] x_sub;

  assign u_ge_v = (u >= v);

  // halving x mod p: add p first when odd so the shift stays exact
  assign h_x   = !u[0] ? x1 : x2;
  assign h_sum = {1'b0, h_x} + (h_x[0] ? {1'b0, p} : '0);
  assign h_out = h_sum[WIDTH:1];

  assign s_a   = u_ge_v ? u : v;
  assign s_b   = u_ge_v ? v : u;
  assign xs_a  = u_ge_v ? x1 : x2;
  assign xs_b  = u_ge_v ? x2 : x1;
  assign x_dif = {1'b0, xs_a} - {1'b0, xs_b};
  assign x_sub = x_dif[WIDTH] ? x_dif[WIDTH-1:0] + p
                              : x_dif[WIDTH-1:0];

  always_comb begin
    u_n  = u;
    v_n  = v;
    x1_n = x1;
    x2_n = x2;
    if (!u[0]) begin
      u_n  = u >> 1;
      x1_n = h_out;
    end else if (!v[0]) begin
      v_n  = v >> 1;
      x2_n = h_out;
    end else if (u_ge_v) begin
      u_n  = s_a - s_b;
      x1_n = x_sub;
    end else begin
      v_n  = s_a - s_b;
      x2_n = x_sub;
    end
  end

endmodule

// File: rtl/gf_div_seq.sv
// Sequential GF(p) divider / inverter, one Euclidean step per clock.
// Start/busy/done handshake, operand checks and a step cap.
module gf_div_seq
  import gf_div_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int MAX_STEPS = 4 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_select,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result_div
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_STEPS);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] u_s, v_s, x1_s, x2_s;
  logic             bad_op;

  gf_bee_step #(.WIDTH(WIDTH)) u_step (
    .u    (u_q),
    .v    (v_q),
    .x1   (x1_q),
    .x2   (x2_q),
    .p    (p_q),
    .u_n  (u_s),
    .v_n  (v_s),
    .x1_n (x1_s),
    .x2_n (x2_s)
  );

  assign bad_op = (a == '0) | ~p[0] | (p == ONE);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_d   = p;
          u_d   = a;
          v_d   = p;
          x1_d  = (mode_select == MODE_DIV) ? b : ONE;
          x2_d  = '0;
          cnt_d = '0;
          res_d = '0;
          err_d = bad_op;
          state_d = bad_op ? DONE : ITER;
        end
      end
      ITER: begin
        if (u_q == ONE) begin
          res_d   = x1_q;
          state_d = DONE;
        end else if (v_q == ONE) begin
          res_d   = x2_q;
          state_d = DONE;
        end else if (cnt_q == CAP) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = DONE;
        end else begin
          u_d   = u_s;
          v_d   = v_s;
          x1_d  = x1_s;
          x2_d  = x2_s;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // working registers are don't-care out of reset
  always_ff @(posedge clk) begin
    p_q   <= p_d;
    u_q   <= u_d;
    v_q   <= v_d;
    x1_q  <= x1_d;
    x2_q  <= x2_d;
    cnt_q <= cnt_d;
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = err_q;
  assign result_div = res_q;

endmodule

// File: tb/tb_gf_div_seq.sv
// Bench for gf_div_seq: 8-bit and 256-bit instances against a
// behavioural Euclidean model plus hand-computed literal results.
module tb_gf_div_seq;

  localparam int W = 256;
  localparam logic [W-1:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st8 = 1'b0;
  logic st256 = 1'b0;
  logic mode = 1'b0;
  logic [W-1:0] p_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;

  logic busy8, done8, err8;
  logic [7:0] res8;
  logic busy256, done256, err256;
  logic [W-1:0] res256;

  always #5 clk = ~clk;

  gf_div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .mode_select(mode),
    .p(p_i[7:0]), .a(a_i[7:0]), .b(b_i[7:0]),
    .busy(busy8), .done(done8), .error(err8), .result_div(res8)
  );

  gf_div_seq #(.WIDTH(W)) dut256 (
    .clk(clk), .rst(rst), .start(st256), .mode_select(mode),
    .p(p_i), .a(a_i), .b(b_i),
    .busy(busy256), .done(done256), .error(err256),
    .result_div(res256)
  );

  bit sel = 1'b0;
  logic busy_m, done_m, err_m;
  logic [W-1:0] res_m;
  always_comb begin
    busy_m = sel ? busy256 : busy8;
    done_m = sel ? done256 : done8;
    err_m  = sel ? err256 : err8;
    res_m  = sel ? res256 : {{(W-8){1'b0}}, res8};
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, exp);
    end
  endtask

  // plain-arithmetic statement of the algorithm; lat = cycles e0 -> done
  function automatic void model(input logic [W-1:0] p, a, b,
                                input bit m, input int maxs,
                                output logic [W-1:0] r, output bit e,
                                output int lat);
    logic [W+1:0] u, v, x1, x2, pp;
    int n;
    bit fin;
    r = '0; e = 1'b0; lat = 0;
    if (a == 0 || p % 2 == 0 || p == 1) begin
      e = 1'b1;
      return;
    end
    pp = {2'b0, p};
    u = {2'b0, a}; v = pp;
    x1 = m ? {2'b0, b} : 1; x2 = 0;
    n = 0; fin = 1'b0;
    while (!fin) begin
      if (u == 1) begin r = x1[W-1:0]; fin = 1'b1; end
      else if (v == 1) begin r = x2[W-1:0]; fin = 1'b1; end
      else if (n == maxs) begin e = 1'b1; fin = 1'b1; end
      else begin
        if (u % 2 == 0) begin
          u = u / 2;
          x1 = (x1 % 2 == 0) ? x1 / 2 : (x1 + pp) / 2;
        end else if (v % 2 == 0) begin
          v = v / 2;
          x2 = (x2 % 2 == 0) ? x2 / 2 : (x2 + pp) / 2;
        end else if (u >= v) begin
          u = u - v;
          x1 = (x1 >= x2) ? x1 - x2 : x1 + pp - x2;
        end else begin
          v = v - u;
          x2 = (x2 >= x1) ? x2 - x1 : x2 + pp - x1;
        end
        n++;
      end
    end
    lat = n + 1;
  endfunction

  logic [W-1:0] exp_res, got_res;
  bit exp_err, got_err;
  int exp_lat, got_lat, cyc;
  bit armed = 1'b0;
  bit post = 1'b0;

  // compare process: every cycle of an operation and the one after it
  always @(negedge clk) begin
    if (armed) begin
      chk("busy_hi", W'(busy_m), W'(1));
      if (done_m) begin
        chk("latency", W'(cyc), W'(exp_lat));
        chk("result", res_m, exp_res);
        chk("error", W'(err_m), W'(exp_err));
        got_res = res_m;
        got_err = err_m;
        got_lat = cyc;
        armed = 1'b0;
        post = 1'b1;
      end else begin
        cyc++;
      end
    end else if (post) begin
      chk("busy_fall", W'(busy_m), W'(0));
      chk("done_pulse", W'(done_m), W'(0));
      post = 1'b0;
    end
  end

  task automatic run(input bit s, input bit m,
                     input logic [W-1:0] p, a, b, input int poke);
    logic [W-1:0] r;
    bit e;
    int lat;
    model(p, a, b, m, s ? 4 * W : 32, r, e, lat);
    @(negedge clk);
    sel = s; mode = m; p_i = p; a_i = a; b_i = b;
    if (s) st256 = 1'b1; else st8 = 1'b1;
    exp_res = r; exp_err = e; exp_lat = lat;
    @(posedge clk);
    #1;
    st8 = 1'b0; st256 = 1'b0;
    cyc = 0; armed = 1'b1;
    for (int i = 0; i < 3000 && armed; i++) begin
      @(posedge clk);
      if (i == poke) begin
        #1;
        p_i = 11; a_i = 5; b_i = 2; mode = ~m;
        if (s) st256 = 1'b1; else st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0; st256 = 1'b0;
      end
    end
    if (armed) begin
      total++; bad++;
      $display("FAIL timeout no done p=%h a=%h", p, a);
      armed = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check_prod(input string n, input logic [W-1:0] a,
                            input logic [W-1:0] want);
    logic [2*W-1:0] prod;
    prod = (2*W)'(a) * (2*W)'(got_res);
    chk(n, W'(prod % (2*W)'(P256)), want);
  endtask

  initial begin
    logic [W-1:0] r, ra, rb;
    bit e, m;
    int lat;

    repeat (3) @(negedge clk);
    chk("rst_busy", W'({busy8, busy256}), W'(0));
    chk("rst_done", W'({done8, done256}), W'(0));
    chk("rst_err", W'({err8, err256}), W'(0));
    chk("rst_res", res256 | W'(res8), W'(0));
    rst = 1'b0;

    // pin the model itself
    model(7, 3, 0, 0, 32, r, e, lat);
    chk("model_inv7", r, 5);
    model(7, 3, 4, 1, 32, r, e, lat);
    chk("model_div7", r, 6);
    model(7, 0, 0, 0, 32, r, e, lat);
    chk("model_err", W'(e), W'(1));

    run(0, 0, 7, 3, 0, -1);
    chk("lit_inv7", got_res, 5);
    chk("n_le_30", W'(got_lat <= 31), W'(1));
    run(0, 1, 7, 3, 4, -1);
    chk("lit_div7", got_res, 6);
    run(0, 1, 7, 1, 4, -1);
    chk("lit_a1", got_res, 4);
    chk("lit_a1_lat", W'(got_lat), W'(1));

    run(0, 0, 7, 0, 0, -1);
    chk("lit_a0_err", W'(got_err), W'(1));
    chk("lit_a0_res", got_res, 0);
    chk("lit_a0_lat", W'(got_lat), W'(0));
    run(0, 0, 8, 3, 0, -1);
    chk("lit_p8_err", W'(got_err), W'(1));
    chk("lit_p8_lat", W'(got_lat), W'(0));

    // a == p never reaches 1: cap ends it after 32 updates
    run(0, 0, 7, 7, 0, -1);
    chk("cap_err", W'(got_err), W'(1));
    chk("cap_lat", W'(got_lat), W'(33));

    run(0, 0, 7, 3, 0, 0);
    chk("poke_keep", got_res, 5);
    run(0, 1, 11, 5, 2, -1);
    chk("lit_div11", got_res, 7);

    run(1, 0, P256, 2, 0, -1);
    chk("lit_p256_half", got_res, W'(({1'b0, P256} + 1) >> 1));

    for (int i = 0; i < 30; i++) begin
      ra = rnd() % (P256 - 1) + 1;
      rb = rnd() % P256;
      m = i[0];
      run(1, m, P256, ra, rb, (i % 5 == 0) ? 7 : -1);
      check_prod("rand_prod", ra, m ? rb : W'(1));
    end

    // abort mid-iteration
    @(negedge clk);
    sel = 1'b1; mode = 1'b0; p_i = P256; a_i = 3;
    st256 = 1'b1;
    @(negedge clk);
    st256 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", W'(busy256), W'(0));
    chk("abort_done", W'(done256), W'(0));
    chk("abort_err", W'(err256), W'(0));
    chk("abort_res", res256, 0);
    begin
      bit seen;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (done256) seen = 1'b1;
      end
      chk("abort_no_done", W'(seen), W'(0));
    end

    run(1, 1, P256, 3, 5, -1);
    check_prod("post_rst_prod", 3, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
